mac_accum_drain: RTL and testbench
==================================

MAC_ACCUM_DRAIN -- requirements
Module: mac_accum_drain

Interface
REQ-001 Parameter IN_W, default 32, is the signed width of each partial-sum input (the dual 8-bit MAC result word).
REQ-002 Parameter ACC_W, default 32, is the signed accumulator width; ACC_W SHALL be >= IN_W.
REQ-003 Parameter OUT_W, default 16, is the signed output width.
REQ-004 clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 resetn  in  1  reset, asynchronous, active-low.
REQ-006 cfg_valid  in  1  a job descriptor is offered.
REQ-007 cfg_ready  out  1  the block accepts a descriptor.
REQ-008 cfg_count  in  16  number of partial sums to accumulate (0..65535).
REQ-009 cfg_shift  in  5  arithmetic right-shift amount applied before narrowing.
REQ-010 in_valid  in  1  in_data is valid.
REQ-011 in_ready  out  1  the block accepts in_data.
REQ-012 in_data  in  IN_W  signed partial sum from the MAC stage.
REQ-013 out_valid  out  1  out_data and out_sat are valid.
REQ-014 out_ready  in  1  the downstream stage accepts the output.
REQ-015 out_data  out  OUT_W  signed shifted, saturated accumulation.
REQ-016 out_sat  out  1  saturation occurred anywhere in this job.

Function
REQ-017 The FSM SHALL have the states IDLE, ACCUM and DRAIN; cfg_ready=1 only in IDLE, in_ready=1 only in ACCUM, out_valid=1 only in DRAIN.
REQ-018 IDLE, on cfg_valid: latch cfg_count and cfg_shift, clear acc and the sticky sat flag; go to ACCUM if count>0, else go to DRAIN with acc=0.
REQ-019 ACCUM, on each in_valid&&in_ready: acc <= sat_ACC_W(acc + sext(in_data)); set the sticky flag on clip; decrement the remaining count.
REQ-020 On acceptance of the input that brings the remaining count from 1 to 0: go to DRAIN; out_valid SHALL rise the next cycle (latency 1 from the last accepted input).
REQ-021 out_data SHALL be registered on DRAIN entry as sat_OUT_W(acc >>> shift), with truncation toward minus infinity and no rounding; out_sat = sticky | (narrowing clipped).
REQ-022 In DRAIN, out_data/out_sat SHALL hold stable while out_ready=0; on out_valid&&out_ready go to IDLE; cfg_ready rises the following cycle (no same-cycle reuse).
REQ-023 Input cycles with in_valid=0 in ACCUM SHALL leave acc and the count unchanged; there is no timeout.
REQ-024 Saturation limits SHALL be 2^(W-1)-1 and -2^(W-1) for the respective width W.

Reset
REQ-025 resetn=0 SHALL immediately force state=IDLE, acc=0, count=0, sticky=0, out_valid=0, out_data=0, out_sat=0, in_ready=0, cfg_ready=0.
REQ-026 cfg_ready SHALL rise in the first clock cycle after resetn deasserts.
REQ-027 Reset during ACCUM or DRAIN SHALL abort the job; no partial result is emitted.

Structure
REQ-028 Package mac_accum_pkg SHALL hold the state enum, the default width constants and the saturation helper function.
REQ-029 The combinational shift-and-narrow path SHALL be a sub-module sat_shift_narrow (ACC_W in, OUT_W out, clip flag).

Verification
REQ-030 count=4, shift=0, inputs 10,20,-5,7 -> out_data=32, out_sat=0, out_valid exactly one cycle after the 4th accept.
REQ-031 count=2, shift=16, inputs 0x7FFFFFF0, 0x00000100 -> acc clips to 0x7FFFFFFF, out_data=0x7FFF, out_sat=1.
REQ-032 count=0 -> in_ready stays 0, out_valid=1 one cycle after cfg accept, out_data=0, out_sat=0.
REQ-033 count=1, shift=3, input -9 -> out_data=-2 (floor), out_sat=0.
REQ-034 out_ready held 0 for 5 cycles in DRAIN -> out_data stable, in_ready=0, cfg_ready=0; IDLE one cycle after out_ready=1.
REQ-035 resetn pulsed low after 2 of 4 inputs -> all outputs 0 asynchronously, no output emitted; a new count=1 job with input 5 then yields out_data=5.

Source files
------------

// File: rtl/mac_accum_drain_pkg.sv
// Shared types, widths and the saturation range test for the MAC accumulate-and-drain block.
package mac_accum_pkg;
  localparam int DEF_IN_W  = 32;
  localparam int DEF_ACC_W = 32;
  localparam int DEF_OUT_W = 16;
  localparam int CNT_W     = 16;
  localparam int SHIFT_W   = 5;
  localparam int MAXW      = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  // {over, under}: where v falls outside the signed w-bit range (w < MAXW).
  function automatic logic [1:0] sat_ovf(input logic signed [MAXW-1:0] v, input int w);
    logic signed [MAXW-1:0] lim;
    lim     = 64'sd1 <<< (w - 1);
    sat_ovf = {v >= lim, v < -lim};
  endfunction
endpackage

// File: rtl/mac_accum_drain_if.sv
// Descriptor, partial-sum and result channels of the accumulate-and-drain block.
interface mac_accum_drain_if
  import mac_accum_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W
);
  logic                    cfg_valid;
  logic                    cfg_ready;
  logic [CNT_W-1:0]        cfg_count;
  logic [SHIFT_W-1:0]      cfg_shift;
  logic                    in_valid;
  logic                    in_ready;
  logic signed [IN_W-1:0]  in_data;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [OUT_W-1:0] out_data;
  logic                    out_sat;

  modport slave (
    input  cfg_valid, cfg_count, cfg_shift, in_valid, in_data, out_ready,
    output cfg_ready, in_ready, out_valid, out_data, out_sat
  );

  modport master (
    output cfg_valid, cfg_count, cfg_shift, in_valid, in_data, out_ready,
    input  cfg_ready, in_ready, out_valid, out_data, out_sat
  );
endinterface

// File: rtl/mac_accum_drain_sat_shift_narrow.sv
// Arithmetic right shift (floor) of the accumulator, then saturating narrow to OUT_W.
module sat_shift_narrow
  import mac_accum_pkg::*;
#(
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  logic [SHIFT_W-1:0]      shift_i,
  output logic signed [OUT_W-1:0] data_o,
  output logic                    clip_o
);
  logic signed [ACC_W-1:0] shifted;
  logic [1:0]              ovf;

  assign shifted = acc_i >>> shift_i;
  assign ovf     = sat_ovf(MAXW'(shifted), OUT_W);

  always_comb begin
    clip_o = |ovf;
    data_o = shifted[OUT_W-1:0];
    if (ovf[1])      data_o = {1'b0, {(OUT_W-1){1'b1}}};
    else if (ovf[0]) data_o = {1'b1, {(OUT_W-1){1'b0}}};
  end
endmodule

// File: rtl/mac_accum_drain.sv
// Accumulates cfg_count signed partial sums with saturation, then presents one
// shifted, narrowed result with a sticky saturation flag until it is taken.
module mac_accum_drain
  import mac_accum_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int ACC_W = DEF_ACC_W,
  parameter int OUT_W = DEF_OUT_W
) (
  input  logic             clock,
  input  logic             resetn,
  mac_accum_drain_if.slave bus
);
  state_t                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [SHIFT_W-1:0]      shift_q, shift_d;
  logic                    sticky_q, sticky_d;
  logic signed [OUT_W-1:0] odata_q, odata_d;
  logic                    osat_q, osat_d;
  // Holds cfg_ready low while reset is asserted even though the state is IDLE.
  logic                    alive_q;

  logic signed [IN_W-1:0]  in_data;
  logic signed [MAXW-1:0]  sum;
  logic [1:0]              acc_ovf;
  logic signed [ACC_W-1:0] acc_sat;
  logic signed [OUT_W-1:0] nar_data;
  logic                    nar_clip;

  assign in_data = bus.in_data;
  assign sum     = MAXW'(acc_q) + MAXW'(in_data);
  assign acc_ovf = sat_ovf(sum, ACC_W);

  always_comb begin
    acc_sat = sum[ACC_W-1:0];
    if (acc_ovf[1])      acc_sat = {1'b0, {(ACC_W-1){1'b1}}};
    else if (acc_ovf[0]) acc_sat = {1'b1, {(ACC_W-1){1'b0}}};
  end

  // Narrowing looks at the post-add value so the last input lands in the result.
  sat_shift_narrow #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_narrow (
    .acc_i   (acc_sat),
    .shift_i (shift_q),
    .data_o  (nar_data),
    .clip_o  (nar_clip)
  );

  assign bus.cfg_ready = alive_q && (state_q == IDLE);
  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_data  = odata_q;
  assign bus.out_sat   = osat_q;

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    shift_d  = shift_q;
    sticky_d = sticky_q;
    odata_d  = odata_q;
    osat_d   = osat_q;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid && alive_q) begin
          cnt_d    = bus.cfg_count;
          shift_d  = bus.cfg_shift;
          acc_d    = '0;
          sticky_d = 1'b0;
          if (bus.cfg_count != '0) begin
            state_d = ACCUM;
          end else begin
            state_d = DRAIN;
            odata_d = '0;
            osat_d  = 1'b0;
          end
        end
      end
      ACCUM: begin
        if (bus.in_valid) begin
          acc_d    = acc_sat;
          sticky_d = sticky_q | (|acc_ovf);
          cnt_d    = cnt_q - CNT_W'(1);
          if (cnt_q == CNT_W'(1)) begin
            state_d = DRAIN;
            odata_d = nar_data;
            osat_d  = sticky_q | (|acc_ovf) | nar_clip;
          end
        end
      end
      DRAIN: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      cnt_q    <= '0;
      shift_q  <= '0;
      sticky_q <= 1'b0;
      odata_q  <= '0;
      osat_q   <= 1'b0;
      alive_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      shift_q  <= shift_d;
      sticky_q <= sticky_d;
      odata_q  <= odata_d;
      osat_q   <= osat_d;
      alive_q  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_mac_accum_drain.sv
// Randomized and directed jobs checked every cycle against an arithmetic model of the job result.
module tb_mac_accum_drain;
  import mac_accum_pkg::*;

  localparam longint AMAX = 64'sd2147483647;
  localparam longint AMIN = -64'sd2147483648;
  localparam longint OMAX = 64'sd32767;
  localparam longint OMIN = -64'sd32768;

  logic clock  = 1'b0;
  logic resetn = 1'b0;

  mac_accum_drain_if bus ();

  mac_accum_drain dut (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus)
  );

  always #5 clock = ~clock;

  int     total = 0;
  int     bad   = 0;
  int     nout  = 0;
  int     njobs = 0;
  longint exp_d[$];
  bit     exp_s[$];
  longint job_in[$];
  longint last_d = 0;
  bit     last_s = 1'b0;

  task automatic chk(input string nm, input longint act, input longint want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, want);
    end
  endtask

  // Job result straight from the rules: clip the running sum, floor-shift, clip to 16 bits.
  function automatic void model_push(input int sh);
    longint acc = 0;
    longint s;
    bit     st = 1'b0;
    foreach (job_in[i]) begin
      acc += job_in[i];
      if (acc > AMAX) begin acc = AMAX; st = 1'b1; end
      else if (acc < AMIN) begin acc = AMIN; st = 1'b1; end
    end
    s = acc >>> sh;
    if (s > OMAX) begin s = OMAX; st = 1'b1; end
    else if (s < OMIN) begin s = OMIN; st = 1'b1; end
    exp_d.push_back(s);
    exp_s.push_back(st);
  endfunction

  always @(negedge clock) begin
    if (resetn) begin
      chk("one_ready_at_a_time",
          longint'(int'(bus.cfg_ready) + int'(bus.in_ready) + int'(bus.out_valid) > 1), 0);
      if (bus.out_valid) begin
        if (exp_d.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_out: out_valid=1 with no job pending, want 0");
        end else begin
          chk("out_data", bus.out_data, exp_d[0]);
          chk("out_sat", bus.out_sat, exp_s[0]);
          if (bus.out_ready) begin
            last_d = bus.out_data;
            last_s = bus.out_sat;
            void'(exp_d.pop_front());
            void'(exp_s.pop_front());
            nout++;
          end
        end
      end
    end
  end

  task automatic send_cfg(input int cnt, input int sh);
    bit ok = 1'b0;
    int g  = 0;
    bus.cfg_valid = 1'b1;
    bus.cfg_count = 16'(cnt);
    bus.cfg_shift = 5'(sh);
    while (!ok && g < 50) begin
      @(negedge clock); ok = bus.cfg_ready;
      @(posedge clock); #1; g++;
    end
    bus.cfg_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL cfg_timeout: cfg_ready=0 for 50 cycles, want 1");
    end
  endtask

  task automatic send_in(input longint v);
    bit ok = 1'b0;
    int g  = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'(v);
    while (!ok && g < 50) begin
      @(negedge clock); ok = bus.in_ready;
      @(posedge clock); #1; g++;
    end
    bus.in_valid = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL in_timeout: in_ready=0 for 50 cycles, want 1");
    end
  endtask

  // Runs one job over job_in; leaves at #1 after a rising edge.
  task automatic run_job(input int sh, input int gap, input int stall);
    int cnt = job_in.size();
    bit ok  = 1'b0;
    int g   = 0;
    njobs++;
    model_push(sh);
    send_cfg(cnt, sh);
    if (cnt == 0) begin
      @(negedge clock);
      chk("cnt0_out_valid", bus.out_valid, 1);
      chk("cnt0_in_ready", bus.in_ready, 0);
      @(posedge clock); #1;
    end else begin
      foreach (job_in[i]) begin
        repeat ($urandom_range(0, gap)) begin @(posedge clock); #1; end
        send_in(job_in[i]);
      end
      @(negedge clock);
      chk("drain_latency", bus.out_valid, 1);
      @(posedge clock); #1;
    end
    repeat (stall) begin
      @(negedge clock);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_cfg_ready", bus.cfg_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      @(posedge clock); #1;
    end
    bus.out_ready = 1'b1;
    while (!ok && g < 50) begin
      @(negedge clock); ok = bus.out_valid;
      @(posedge clock); #1; g++;
    end
    bus.out_ready = 1'b0;
    if (!ok) begin
      total++; bad++;
      $display("FAIL out_timeout: out_valid=0 for 50 cycles, want 1");
    end
    @(negedge clock);
    chk("idle_after_drain", bus.cfg_ready, 1);
    @(posedge clock); #1;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_cfg_ready"}, bus.cfg_ready, 0);
    chk({tag, "_in_ready"}, bus.in_ready, 0);
    chk({tag, "_out_valid"}, bus.out_valid, 0);
    chk({tag, "_out_data"}, bus.out_data, 0);
    chk({tag, "_out_sat"}, bus.out_sat, 0);
  endtask

  function automatic longint rnd_val();
    case ($urandom_range(0, 3))
      0:       return longint'(int'($urandom()));
      1:       return 64'sd2147483647 - longint'($urandom_range(0, 1000));
      2:       return -64'sd2147483648 + longint'($urandom_range(0, 1000));
      default: return longint'($urandom_range(0, 2000)) - 1000;
    endcase
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running at time limit, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.cfg_valid = 1'b0;
    bus.cfg_count = '0;
    bus.cfg_shift = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    #12;
    chk_reset_outputs("por");
    @(negedge clock); resetn = 1'b1;
    #1 chk("cfg_ready_pre_edge", bus.cfg_ready, 0);
    @(posedge clock); #1;
    chk("cfg_ready_first_cycle", bus.cfg_ready, 1);

    job_in = {10, 20, -5, 7};
    run_job(0, 0, 0);
    chk("sum4_data", last_d, 32);
    chk("sum4_sat", last_s, 0);

    job_in = {64'sh7FFFFFF0, 64'sh100};
    run_job(16, 1, 0);
    chk("accclip_data", last_d, 32767);
    chk("accclip_sat", last_s, 1);

    job_in.delete();
    run_job(7, 0, 0);
    chk("cnt0_data", last_d, 0);
    chk("cnt0_sat", last_s, 0);

    job_in = {-9};
    run_job(3, 0, 0);
    chk("floor_data", last_d, -2);
    chk("floor_sat", last_s, 0);

    job_in = {100, -300};
    run_job(2, 2, 5);
    chk("stall_data", last_d, -50);

    job_in = {64'sd70000};
    run_job(0, 0, 0);
    chk("narrowclip_data", last_d, 32767);
    chk("narrowclip_sat", last_s, 1);

    // Abort a job mid-accumulation; nothing of it may reach the output.
    send_cfg(4, 0);
    send_in(3);
    send_in(4);
    @(negedge clock); #2;
    resetn = 1'b0;
    #1 chk_reset_outputs("abort");
    @(posedge clock); @(negedge clock);
    resetn = 1'b1;
    #1 chk("abort_cfg_ready_pre_edge", bus.cfg_ready, 0);
    @(posedge clock); #1;
    chk("abort_cfg_ready_first_cycle", bus.cfg_ready, 1);
    chk("abort_nothing_pending", exp_d.size(), 0);
    job_in = {5};
    run_job(0, 0, 0);
    chk("post_abort_data", last_d, 5);

    for (int j = 0; j < 60; j++) begin
      int n;
      n = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      job_in.delete();
      for (int k = 0; k < n; k++) job_in.push_back(rnd_val());
      run_job($urandom_range(0, 31), 2, $urandom_range(0, 3));
    end

    repeat (3) @(posedge clock);
    chk("final_pending", exp_d.size(), 0);
    chk("final_outputs", nout, njobs);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
